// File: rtl/tva_pkg.sv
// Shared precision-code definitions used by the precision analyzer and the value quantizer.
// Also holds the quantizer FSM state type and the code-to-width helpers.
package tva_pkg;

    localparam int PREC_CODE_W = 4;

    typedef enum logic [1:0] {
        PREC_INT4 = 2'd0,
        PREC_INT8 = 2'd1,
        PREC_FP16 = 2'd2
    } prec_code_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } tva_state_t;

    // Any raw code of 3 or above collapses to FP16.
    function automatic prec_code_t prec_effective(input logic [PREC_CODE_W-1:0] raw);
        prec_code_t c;
        if (raw >= PREC_CODE_W'(2)) begin
            c = PREC_FP16;
        end else begin
            c = prec_code_t'(raw[1:0]);
        end
        return c;
    endfunction

    function automatic logic [31:0] prec_bits(input prec_code_t code);
        logic [31:0] b;
        case (code)
            PREC_INT4: b = 32'd4;
            PREC_INT8: b = 32'd8;
            default:   b = 32'd16;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/value_requant.sv
// Combinational requantizer: rounds half-up by arithmetic shift and saturates to the
// INT4/INT8 range, or passes the element through unchanged for FP16.
module value_requant
    import tva_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]  x,
    input  logic [PREC_CODE_W-1:0] code,
    output logic [DATA_WIDTH-1:0]  q,
    output prec_code_t             eff_code
);

    localparam int W  = DATA_WIDTH + 1;
    localparam int S8 = DATA_WIDTH - 8;
    localparam int S4 = DATA_WIDTH - 4;

    localparam logic signed [W-1:0] RND8 = W'(1 << (S8 - 1));
    localparam logic signed [W-1:0] RND4 = W'(1 << (S4 - 1));
    localparam logic signed [W-1:0] MAX8 = W'(127);
    localparam logic signed [W-1:0] MIN8 = W'(-128);
    localparam logic signed [W-1:0] MAX4 = W'(7);
    localparam logic signed [W-1:0] MIN4 = W'(-8);

    logic signed [W-1:0]          x_ext;
    logic signed [W-1:0]          sh8;
    logic signed [W-1:0]          sh4;
    logic        [DATA_WIDTH-1:0] sat8;
    logic        [DATA_WIDTH-1:0] sat4;

    // One guard bit keeps x + rounding constant from overflowing near +max.
    always_comb begin
        x_ext = {x[DATA_WIDTH-1], x};
        sh8   = (x_ext + RND8) >>> S8;
        sh4   = (x_ext + RND4) >>> S4;

        if (sh8 > MAX8) begin
            sat8 = MAX8[DATA_WIDTH-1:0];
        end else if (sh8 < MIN8) begin
            sat8 = MIN8[DATA_WIDTH-1:0];
        end else begin
            sat8 = sh8[DATA_WIDTH-1:0];
        end

        if (sh4 > MAX4) begin
            sat4 = MAX4[DATA_WIDTH-1:0];
        end else if (sh4 < MIN4) begin
            sat4 = MIN4[DATA_WIDTH-1:0];
        end else begin
            sat4 = sh4[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        eff_code = prec_effective(code);
        case (eff_code)
            PREC_INT4: q = sat4;
            PREC_INT8: q = sat8;
            default:   q = x;
        endcase
    end

endmodule

// File: rtl/token_value_quantizer.sv
// Streams a token-major value matrix and requantizes each element to its token's precision,
// accumulating the storage-bit total for the pass.
//
//   state  | meaning
//   S_IDLE | waiting for start; codes latched on start
//   S_RUN  | accepting elements and handing off quantized results
//   S_DONE | last element handed off; done pulses for this one cycle
module token_value_quantizer
    import tva_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int D          = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PREC_CODE_W*L-1:0] token_prec,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [1:0]               out_code,
    output logic                     out_last,
    output logic [31:0]              storage_bits,
    output logic                     done
);

    localparam int TOK_W  = (L > 1) ? $clog2(L) : 1;
    localparam int FEAT_W = (D > 1) ? $clog2(D) : 1;

    tva_state_t               state_q, state_d;
    logic [TOK_W-1:0]         tok_q, tok_d;
    logic [FEAT_W-1:0]        feat_q, feat_d;
    logic                     all_q, all_d;
    logic [PREC_CODE_W*L-1:0] codes_q, codes_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [1:0]               out_code_q, out_code_d;
    logic                     out_last_q, out_last_d;
    logic [31:0]              storage_q, storage_d;

    logic                     in_ready_c;
    logic                     accept;
    logic                     handoff;
    logic                     tok_last;
    logic                     feat_last;
    logic [PREC_CODE_W-1:0]   cur_code;
    logic [DATA_WIDTH-1:0]    rq_data;
    prec_code_t               rq_code;

    assign cur_code = codes_q[PREC_CODE_W*int'(tok_q) +: PREC_CODE_W];

    value_requant #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_requant (
        .x        (in_data),
        .code     (cur_code),
        .q        (rq_data),
        .eff_code (rq_code)
    );

    always_comb begin
        state_d     = state_q;
        tok_d       = tok_q;
        feat_d      = feat_q;
        all_d       = all_q;
        codes_d     = codes_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_code_d  = out_code_q;
        out_last_d  = out_last_q;
        storage_d   = storage_q;

        tok_last   = (tok_q == TOK_W'(L - 1));
        feat_last  = (feat_q == FEAT_W'(D - 1));
        in_ready_c = (state_q == S_RUN) && !all_q && (!out_valid_q || out_ready);
        accept     = in_valid && in_ready_c;
        handoff    = out_valid_q && out_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    codes_d   = token_prec;
                    tok_d     = '0;
                    feat_d    = '0;
                    all_d     = 1'b0;
                    storage_d = '0;
                end
            end
            S_RUN: begin
                // A reload on accept takes priority, so a simultaneous handoff keeps the stream gapless.
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rq_data;
                    out_code_d  = rq_code;
                    out_last_d  = tok_last && feat_last;
                    storage_d   = storage_q + prec_bits(rq_code);
                    if (feat_last) begin
                        feat_d = '0;
                        tok_d  = tok_last ? '0 : tok_q + 1'b1;
                        all_d  = tok_last;
                    end else begin
                        feat_d = feat_q + 1'b1;
                    end
                end else if (handoff) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end

                if (handoff && out_last_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tok_q       <= '0;
            feat_q      <= '0;
            all_q       <= 1'b0;
            codes_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_code_q  <= '0;
            out_last_q  <= 1'b0;
            storage_q   <= '0;
        end else begin
            state_q     <= state_d;
            tok_q       <= tok_d;
            feat_q      <= feat_d;
            all_q       <= all_d;
            codes_q     <= codes_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_code_q  <= out_code_d;
            out_last_q  <= out_last_d;
            storage_q   <= storage_d;
        end
    end

    assign in_ready     = in_ready_c;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_code     = out_code_q;
    assign out_last     = out_last_q;
    assign storage_bits = storage_q;
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_token_value_quantizer.sv
// Randomized bench for token_value_quantizer against an arithmetic reference model
// (floor-divide rounding, explicit clamps, per-token code lookup).
module tb_token_value_quantizer;

    localparam int DW = 16;
    localparam int L  = 8;
    localparam int D  = 4;
    localparam int N  = L * D;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [4*L-1:0] token_prec;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_code;
    logic          out_last;
    logic [31:0]   storage_bits;
    logic          done;

    token_value_quantizer #(
        .DATA_WIDTH (DW),
        .L          (L),
        .D          (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .token_prec   (token_prec),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_code     (out_code),
        .out_last     (out_last),
        .storage_bits (storage_bits),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          last;
        logic [1:0]    code;
        logic [DW-1:0] data;
    } exp_t;

    int          n_tests;
    int          n_fail;
    int          codes_tb[L];
    logic [DW-1:0] vdata[N];
    exp_t        exp_q[$];
    int          pass_bits;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_of(input int c);
        return (c >= 2) ? 2 : c;
    endfunction

    function automatic int bits_of(input int c);
        return (c == 0) ? 4 : (c == 1) ? 8 : 16;
    endfunction

    // round(x / 2^s) half-up via floor division, then clamp to the signed target range
    function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] x, input int code);
        int xi, s, dv, v, q, lo, hi;
        logic [31:0] qv;
        if (code == 2) return x;
        xi = $signed(x);
        s  = (code == 1) ? DW - 8 : DW - 4;
        lo = (code == 1) ? -128 : -8;
        hi = (code == 1) ? 127 : 7;
        dv = 1 << s;
        v  = xi + dv / 2;
        q  = (v >= 0) ? v / dv : -((-v + dv - 1) / dv);
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        qv = q;
        return qv[DW-1:0];
    endfunction

    function automatic logic [4*L-1:0] pack_codes();
        logic [4*L-1:0] p;
        p = '0;
        for (int t = 0; t < L; t++) p[4*t +: 4] = codes_tb[t][3:0];
        return p;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 5))
                0:       vdata[i] = 16'h7FFF;
                1:       vdata[i] = 16'h8000;
                2:       vdata[i] = 16'h0000;
                default: vdata[i] = DW'($urandom);
            endcase
        end
    endtask

    task automatic random_codes();
        for (int t = 0; t < L; t++) codes_tb[t] = $urandom_range(0, 15);
    endtask

    task automatic do_start();
        @(negedge clk);
        token_prec = pack_codes();
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("storage_clear", storage_bits, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
        chk({tag, "_out_code"}, {30'd0, out_code}, 32'd0);
        chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_storage"}, storage_bits, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_pass(input int rdy_pct, input int vld_pct, input int abort_after,
                            input bit mid_start, input bit extra_valid, output int span);
        int   idx, ho_cnt, first_acc, last_ho;
        bit   done_pending, finished, prev_stall, acc, ho;
        logic [DW-1:0] prev_data;
        logic [4*L-1:0] pc;
        exp_t e;
        int   c;

        exp_q.delete();
        pass_bits    = 0;
        idx          = 0;
        ho_cnt       = 0;
        first_acc    = -1;
        last_ho      = -1;
        done_pending = 0;
        finished     = 0;
        prev_stall   = 0;
        prev_data    = '0;
        pc           = pack_codes();
        do_start();

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            out_ready  = ($urandom_range(0, 99) < rdy_pct);
            in_valid   = (idx < N) ? ($urandom_range(0, 99) < vld_pct) : extra_valid;
            in_data    = (idx < N) ? vdata[idx] : 16'hDEAD;
            start      = mid_start && (cyc == 6);
            token_prec = start ? ~pc : pc;
            #1;
            if (done_pending) begin
                chk("done_pulse", {31'd0, done}, 32'd1);
                chk("storage_bits", storage_bits, 32'(pass_bits));
                finished = 1;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
                end
                if (out_valid && !out_ready) chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
                if (idx >= N) chk("in_ready_after_all", {31'd0, in_ready}, 32'd0);
                acc = in_valid && in_ready;
                ho  = out_valid && out_ready;
                if (ho) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", {16'd0, out_data}, {16'd0, e.data});
                        chk("out_code", {30'd0, out_code}, {30'd0, e.code});
                        chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                    end
                    ho_cnt++;
                    last_ho = cyc;
                    if (out_last) done_pending = 1;
                end
                if (acc) begin
                    c = eff_of(codes_tb[idx / D]);
                    e.data = ref_q(vdata[idx], c);
                    e.code = 2'(c);
                    e.last = (idx == N - 1);
                    exp_q.push_back(e);
                    pass_bits += bits_of(c);
                    if (first_acc < 0) first_acc = cyc;
                    idx++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                if (abort_after > 0 && ho_cnt == abort_after) begin
                    rst_n = 1'b0;
                    #1;
                    check_reset_outputs("abort");
                    @(negedge clk);
                    rst_n    = 1'b1;
                    finished = 1;
                end
            end
            if (!finished) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        if (!finished) chk("timeout", 32'd0, 32'd1);
        start    = 1'b0;
        in_valid = 1'b0;
        span     = last_ho - first_acc;
        repeat (3) @(negedge clk);
    endtask

    int span;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        token_prec = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // all INT8, directed corner values first
        for (int t = 0; t < L; t++) codes_tb[t] = 1;
        fill_random();
        vdata[0] = 16'h1234;
        vdata[1] = 16'h7FFF;
        vdata[2] = 16'h8000;
        run_pass(100, 100, 0, 0, 0, span);

        // all INT4
        for (int t = 0; t < L; t++) codes_tb[t] = 0;
        fill_random();
        vdata[0] = 16'h0800;
        vdata[1] = 16'h07FF;
        vdata[2] = 16'h7FFF;
        vdata[3] = 16'h8000;
        run_pass(100, 100, 0, 0, 0, span);

        // mixed codes incl. 3, full-rate stream
        codes_tb = '{0, 1, 2, 3, 0, 1, 2, 2};
        for (int i = 0; i < N; i++) vdata[i] = 16'hFFFF;
        run_pass(100, 100, 0, 0, 0, span);
        chk("throughput_span", 32'(span), 32'd32);
        chk("storage_352", storage_bits, 32'd352);

        // random backpressure and random codes
        for (int p = 0; p < 3; p++) begin
            random_codes();
            fill_random();
            run_pass(50, 70, 0, 0, 0, span);
            chk("storage_hold", storage_bits, 32'(pass_bits));
        end

        // reset mid-pass, then a fresh full pass
        random_codes();
        fill_random();
        run_pass(60, 80, 10, 0, 0, span);
        random_codes();
        fill_random();
        run_pass(70, 90, 0, 0, 0, span);

        // start during S_RUN and extra in_valid after the final element
        random_codes();
        fill_random();
        run_pass(80, 100, 0, 1, 1, span);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
